seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have start_div  input  1  one-cycle request for signed divide.
REQ-005 SHALL have start_divu  input  1  one-cycle request for unsigned divide.
REQ-006 SHALL have dividend  input  WIDTH  rs operand, sampled only on an accepted start.
REQ-007 SHALL have divisor  input  WIDTH  rt operand, sampled only on an accepted start.
REQ-008 SHALL have q  output  WIDTH  quotient, for LO.
REQ-009 SHALL have r  output  WIDTH  remainder, for HI.
REQ-010 SHALL have busy_div / busy_divu  output  1 each  signed / unsigned operation in progress.
REQ-011 SHALL have over_div / over_divu  output  1 each  one-cycle completion pulse for signed / unsigned.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 In IDLE, start_div or start_divu high at a clock edge SHALL latch the operands and the mode and move to RUN; start_div SHALL win if both are high.
REQ-014 Starts arriving in RUN or DONE SHALL be ignored, with no effect on the operation in progress.
REQ-015 The mode's busy output SHALL be high in every RUN cycle: WIDTH cycles, starting the cycle after the start edge.
REQ-016 RUN SHALL perform restoring division at one quotient bit per cycle, MSB first, using a WIDTH-bit iteration counter that counts down from WIDTH-1 to 0.
REQ-017 After the final iteration the FSM SHALL enter DONE for exactly one cycle:
  - the mode's over output is high and busy is low;
  - q and r are valid;
  - the next state is IDLE.
REQ-018 Total latency SHALL be WIDTH+1 cycles from the start edge to the over pulse; a new start SHALL be accepted in the cycle after DONE.
REQ-019 q and r SHALL hold the last result until the next completion.
REQ-020 Signed mode SHALL divide magnitudes, negate q when the operand signs differ, and give r the sign of the dividend.
REQ-021 Signed minimum / -1 SHALL produce q = minimum value and r = 0.
REQ-022 Divisor = 0 SHALL produce q = all ones and r = dividend in both modes.
REQ-023 The busy and over outputs of the mode not selected SHALL stay low throughout.

Reset
REQ-024 rst_n low at a clock edge SHALL force IDLE and clear q, r, all busy/over outputs, the counter and the internal registers to zero.
REQ-025 Reset SHALL abort an operation in progress with no over pulse; rst_n low SHALL override any start in the same cycle.

Configuration
REQ-026 Macro DIV_ZERO_FAST_EN SHALL control divide-by-zero timing.
  - Defined: a zero divisor at start SHALL skip RUN; DONE follows in the next cycle (latency 1, busy never asserted), with the results of REQ-022.
  - Undefined: zero-divisor operations SHALL take the full WIDTH+1 cycles.

Structure
REQ-027 Shared package div_pkg SHALL hold:
  - the FSM state typedef;
  - the default width constant;
  - the divide-by-zero quotient constant.
REQ-028 Sign handling (absolute value in, conditional negate out) SHALL be one sub-module, div_sign_fix, instantiated for the operands and for the results.

Verification
REQ-029 divu 100 / 7 -> over_divu after 33 cycles, busy_divu high 32 cycles, q=14, r=2.
REQ-030 div -100 / 7 -> q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2); div 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
REQ-031 divu 5 / 0 -> q=0xFFFFFFFF, r=5; latency 33 cycles without the macro, 1 cycle with DIV_ZERO_FAST_EN.
REQ-032 start_divu pulsed at cycle 10 of a running div -> ignored, div result correct; start_div and start_divu high together -> signed mode, only busy_div asserts.
REQ-033 rst_n low at cycle 15 of RUN -> next cycle all outputs 0, no over pulse; a new divu 9 / 3 then gives q=3, r=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// default operand width and the divide-by-zero quotient pattern.
package div_pkg;

  // Default operand/result width in bits.
  localparam int DEF_WIDTH = 32;

  // FSM state type, kept as plain encoded constants for compatibility
  // with the older blocks in this codebase.
  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Quotient returned for a zero divisor: all ones. Only bit 0 is needed
  // by users that replicate the pattern to their own width.
  localparam logic [DEF_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation. Used both ways around the
// unsigned divider core: absolute value of the operands on the way in,
// sign restoration of quotient and remainder on the way out.
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg_en,
  output logic [WIDTH-1:0] result
);

  // Negate when requested, otherwise pass through unchanged.
  assign result = neg_en ? ({WIDTH{1'b0}} - value) : value;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Signed (start_div) and unsigned (start_divu) requests share one core;
// signed operations divide magnitudes and fix the signs afterwards.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration
// phase and completes one cycle after the start edge.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_div,
  input  logic             start_divu,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy_div,
  output logic             busy_divu,
  output logic             over_div,
  output logic             over_divu
);

  localparam logic [WIDTH-1:0] ZERO_Q   = {WIDTH{DIV_ZERO_Q[0]}};
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state;
  logic             mode_signed;  // latched mode of the current operation
  logic             neg_q;        // quotient must be negated at the end
  logic             neg_r;        // remainder must be negated at the end
  logic             div_zero;     // divisor was zero at start
  logic [WIDTH-1:0] rem;          // partial remainder
  logic [WIDTH-1:0] quo;          // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs;          // divisor magnitude
  logic [WIDTH-1:0] cnt;          // iteration counter, WIDTH-1 down to 0

  logic             start_any;
  logic             op_signed;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   trial_lhs;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // A start is only meaningful in IDLE; signed wins when both are raised.
  assign start_any = start_div | start_divu;
  assign op_signed = start_div;

  // Operand magnitudes for the unsigned core.
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_dividend (
    .value  (dividend),
    .neg_en (op_signed & dividend[WIDTH-1]),
    .result (dvd_abs)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_divisor (
    .value  (divisor),
    .neg_en (op_signed & divisor[WIDTH-1]),
    .result (dvs_abs)
  );

  // One restoring step: bring down the next dividend bit and subtract the
  // divisor if it fits. The partial remainder always stays below the
  // divisor, so the comparison needs only one extra bit.
  assign trial_lhs = {rem, quo[WIDTH-1]};
  assign trial_ok  = (trial_lhs >= {1'b0, dvs});
  assign rem_next  = trial_ok ? (trial_lhs[WIDTH-1:0] - dvs)
                              : {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign quo_next  = {quo[WIDTH-2:0], trial_ok};

  // Sign restoration of the final step's results.
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
    .value  (quo_next),
    .neg_en (neg_q),
    .result (q_fix)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
    .value  (rem_next),
    .neg_en (neg_r),
    .result (r_fix)
  );

  // FSM, iteration datapath and result registers; synchronous reset.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mode_signed <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_zero    <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      q           <= '0;
      r           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_any) begin
            mode_signed <= op_signed;
            neg_q       <= op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r       <= op_signed & dividend[WIDTH-1];
            div_zero    <= (divisor == '0);
            rem         <= '0;
            quo         <= dvd_abs;
            dvs         <= dvs_abs;
            cnt         <= CNT_LAST;
`ifdef DIV_ZERO_FAST_EN
            if (divisor == '0) begin
              q     <= ZERO_Q;
              r     <= dividend;
              state <= S_DONE;
            end else begin
              state <= S_RUN;
            end
`else
            state       <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt == '0) begin
            // A zero divisor already yields r = dividend through the core;
            // only the signed quotient needs forcing to all ones.
            q     <= div_zero ? ZERO_Q : q_fix;
            r     <= r_fix;
            state <= S_DONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from state and the latched mode.
  assign busy_div  = (state == S_RUN)  &  mode_signed;
  assign busy_divu = (state == S_RUN)  & ~mode_signed;
  assign over_div  = (state == S_DONE) &  mode_signed;
  assign over_divu = (state == S_DONE) & ~mode_signed;

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider (WIDTH = 32), plus
// hand-written sequences for ignored starts, start priority and reset.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_div;
  logic         start_divu;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy_div;
  logic         busy_divu;
  logic         over_div;
  logic         over_divu;

  int n_vec = 0;
  int n_mis = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_div  (start_div),
    .start_divu (start_divu),
    .dividend   (dividend),
    .divisor    (divisor),
    .q          (q),
    .r          (r),
    .busy_div   (busy_div),
    .busy_divu  (busy_divu),
    .over_div   (over_div),
    .over_divu  (over_divu)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eq;
    logic [W-1:0] er;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit zero_fast(input logic [W-1:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == '0);
`else
    return 1'b0;
`endif
  endfunction

  // Issue one operation from IDLE and follow it to completion. Latency is
  // counted with the start cycle as 1. ign_at > 0 pulses the opposite
  // start during that RUN cycle with unrelated operands.
  task automatic run_op(input string tag, input logic sgn, input logic both,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int ign_at);
    int lat      = 0;
    int busy_cnt = 0;
    int wrong    = 0;
    bit seen     = 1'b0;
    int exp_lat;
    int exp_busy;
    exp_lat  = zero_fast(b) ? 1 : W + 1;
    exp_busy = zero_fast(b) ? 0 : W;

    start_div  = sgn | both;
    start_divu = ~sgn | both;
    dividend   = a;
    divisor    = b;
    @(posedge clk); #1;
    start_div  = 1'b0;
    start_divu = 1'b0;
    dividend   = $urandom;
    divisor    = $urandom;

    for (int k = 1; k <= 100 && !seen; k++) begin
      if (sgn ? busy_div : busy_divu) busy_cnt++;
      if (sgn ? (busy_divu | over_divu) : (busy_div | over_div)) wrong++;
      if (sgn ? over_div : over_divu) begin
        seen = 1'b1;
        lat  = k;
      end
      if (!seen) begin
        if (k == ign_at) begin
          start_div  = ~sgn;
          start_divu = sgn;
          dividend   = 32'd9;
          divisor    = 32'd3;
        end
        @(posedge clk); #1;
        start_div  = 1'b0;
        start_divu = 1'b0;
      end
    end

    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " busy cycles"}, W'(busy_cnt), W'(exp_busy));
    check({tag, " other-mode activity"}, W'(wrong), '0);
    check({tag, " q"}, q, eq);
    check({tag, " r"}, r, er);

    // Cycle after DONE: back in IDLE, pulse over, results held.
    @(posedge clk); #1;
    check({tag, " idle flags"}, {28'd0, busy_div, busy_divu, over_div, over_divu}, '0);
    check({tag, " q held"}, q, eq);
  endtask

  initial begin
    vec_t vecs[13];
    int   act_cnt;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
    vecs[4]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2};
    vecs[5]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
    vecs[7]  = '{1'b0, 32'd7,          32'd100,        32'd0,          32'd7};
    vecs[8]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'd10,         32'h19999999,   32'd5};
    vecs[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
    vecs[11] = '{1'b1, 32'd7,          32'd2,          32'd3,          32'd1};
    vecs[12] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};

    rst_n      = 1'b0;
    start_div  = 1'b0;
    start_divu = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset q", q, '0);
    check("reset r", r, '0);
    check("reset flags", {28'd0, busy_div, busy_divu, over_div, over_divu}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sgn, 1'b0, vecs[i].a, vecs[i].b,
             vecs[i].eq, vecs[i].er, -1);
    end

    // Unsigned start in RUN cycle 10 of a signed divide must be ignored.
    run_op("ignored start", 1'b1, 1'b0, 32'hFFFFFF9C, 32'd7,
           32'hFFFFFFF2, 32'hFFFFFFFE, 10);

    // Both starts together: signed mode only.
    run_op("both starts", 1'b1, 1'b1, 32'hFFFFFF9C, 32'd7,
           32'hFFFFFFF2, 32'hFFFFFFFE, -1);

    // Reset in RUN cycle 15 aborts with no completion pulse.
    start_divu = 1'b1;
    dividend   = 32'd100;
    divisor    = 32'd7;
    @(posedge clk); #1;
    start_divu = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("mid-run busy_divu", {31'd0, busy_divu}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort q", q, '0);
    check("abort r", r, '0);
    check("abort flags", {28'd0, busy_div, busy_divu, over_div, over_divu}, '0);
    act_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy_div | busy_divu | over_div | over_divu) act_cnt++;
    end
    check("abort activity", W'(act_cnt), '0);

    // Reset in the same cycle as a start wins.
    rst_n     = 1'b0;
    start_div = 1'b1;
    dividend  = 32'd7;
    divisor   = 32'd2;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    start_div = 1'b0;
    act_cnt = 0;
    repeat (40) begin
      if (busy_div | busy_divu | over_div | over_divu) act_cnt++;
      @(posedge clk); #1;
    end
    check("reset beats start", W'(act_cnt), '0);

    run_op("after reset 9/3", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
